// File: rtl/music_pkg.sv
// Shared constants, FSM encoding and geometry types for the piano-roll plotter.
package music_pkg;
    localparam int SCREEN_W         = 160;
    localparam int SCREEN_H         = 120;
    localparam int BLOCK_W          = 8;
    localparam int BLOCK_H          = 2;
    localparam int SLOT_PITCH       = 10;
    localparam int Y_BASE           = 112;
    localparam int NOTES_PER_OCTAVE = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAW  = 2'd1,
        CLEAR = 2'd2
    } plot_state_e;

    typedef struct packed {
        logic [7:0] org_x;
        logic [6:0] org_y;
        logic [7:0] w;
        logic [6:0] h;
    } rect_t;

    // Higher pitches sit higher on screen: two rows per semitone above y_base.
    function automatic logic [6:0] pitch_y0(input logic [3:0] note,
                                            input logic [1:0] octave,
                                            input logic [6:0] y_base);
        logic [5:0] p;
        p = 6'(octave) * 6'(NOTES_PER_OCTAVE) + 6'(note);
        return y_base - {p, 1'b0};
    endfunction
endpackage

// File: rtl/note_plotter_if.sv
// Request side (note events, clear) and vga_adapter pixel-write side of the plotter.
interface note_plotter_if;
    logic       draw;
    logic       clear;
    logic [3:0] note;
    logic [1:0] octave;
    logic [3:0] slot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       writeEn;
    logic       busy;

    modport master (output draw, clear, note, octave, slot,
                    input  x, y, colour, writeEn, busy);
    modport slave  (input  draw, clear, note, octave, slot,
                    output x, y, colour, writeEn, busy);
endinterface

// File: rtl/note_plotter_scanner.sv
// Raster walker over a rectangle: loads on start, presents the first pixel the
// following cycle and advances one pixel per cycle, x inner.
module rect_scanner
    import music_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    input  rect_t      rect_i,
    output logic [7:0] x_o,
    output logic [6:0] y_o,
    output logic       vld_o,
    output logic       last_o
);
    logic [7:0] x_q, x_d, org_x_q, lim_x_q;
    logic [6:0] y_q, y_d, lim_y_q;
    logic       vld_q, vld_d;
    logic       row_end;

    assign row_end = (x_q == lim_x_q);
    assign last_o  = vld_q && row_end && (y_q == lim_y_q);

    always_comb begin
        x_d   = x_q;
        y_d   = y_q;
        vld_d = vld_q;
        if (start_i) begin
            x_d   = rect_i.org_x;
            y_d   = rect_i.org_y;
            vld_d = 1'b1;
        end else if (vld_q) begin
            // Termination on the last pixel itself; coordinates hold there.
            if (last_o) begin
                vld_d = 1'b0;
            end else if (row_end) begin
                x_d = org_x_q;
                y_d = y_q + 7'd1;
            end else begin
                x_d = x_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q     <= '0;
            y_q     <= '0;
            vld_q   <= 1'b0;
            org_x_q <= '0;
            lim_x_q <= '0;
            lim_y_q <= '0;
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            vld_q <= vld_d;
            if (start_i) begin
                org_x_q <= rect_i.org_x;
                lim_x_q <= rect_i.org_x + rect_i.w - 8'd1;
                lim_y_q <= rect_i.org_y + rect_i.h - 7'd1;
            end
        end
    end

    assign x_o   = x_q;
    assign y_o   = y_q;
    assign vld_o = vld_q;
endmodule

// File: rtl/note_plotter.sv
// Piano-roll plotter: arbitrates draw/clear requests and feeds one rectangle at a
// time through rect_scanner to the vga_adapter pixel port.
module note_plotter #(
    parameter int SCREEN_W   = music_pkg::SCREEN_W,
    parameter int SCREEN_H   = music_pkg::SCREEN_H,
    parameter int BLOCK_W    = music_pkg::BLOCK_W,
    parameter int BLOCK_H    = music_pkg::BLOCK_H,
    parameter int SLOT_PITCH = music_pkg::SLOT_PITCH,
    parameter int Y_BASE     = music_pkg::Y_BASE
) (
    input logic           clk,
    input logic           reset,
    note_plotter_if.slave bus
);
    import music_pkg::rect_t;
    import music_pkg::pitch_y0;

    localparam logic [1:0] S_IDLE  = music_pkg::IDLE;
    localparam logic [1:0] S_DRAW  = music_pkg::DRAW;
    localparam logic [1:0] S_CLEAR = music_pkg::CLEAR;

    logic [1:0] state_q, state_d;
    logic [2:0] colour_q, colour_d;
    logic       start, draw_ok;
    rect_t      rect;
    logic [7:0] sc_x;
    logic [6:0] sc_y;
    logic       sc_vld, sc_last;

    assign draw_ok = bus.draw && (bus.note < 4'(music_pkg::NOTES_PER_OCTAVE));

    always_comb begin
        state_d    = state_q;
        colour_d   = colour_q;
        start      = 1'b0;
        rect.org_x = '0;
        rect.org_y = '0;
        rect.w     = 8'(SCREEN_W);
        rect.h     = 7'(SCREEN_H);
        // Clear beats draw and preempts an in-flight block; a restart of CLEAR is not allowed.
        if (bus.clear && state_q != S_CLEAR) begin
            start    = 1'b1;
            state_d  = S_CLEAR;
            colour_d = 3'd0;
        end else if (state_q == S_IDLE && draw_ok) begin
            start      = 1'b1;
            state_d    = S_DRAW;
            colour_d   = 3'(bus.octave) + 3'd1;
            rect.org_x = 8'(bus.slot) * 8'(SLOT_PITCH);
            rect.org_y = pitch_y0(bus.note, bus.octave, 7'(Y_BASE));
            rect.w     = 8'(BLOCK_W);
            rect.h     = 7'(BLOCK_H);
        end else if (sc_last) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            colour_q <= 3'd0;
        end else begin
            state_q  <= state_d;
            colour_q <= colour_d;
        end
    end

    rect_scanner u_scan (
        .clk     (clk),
        .rst_n   (reset),
        .start_i (start),
        .rect_i  (rect),
        .x_o     (sc_x),
        .y_o     (sc_y),
        .vld_o   (sc_vld),
        .last_o  (sc_last)
    );

    assign bus.x       = sc_x;
    assign bus.y       = sc_y;
    assign bus.colour  = colour_q;
    assign bus.writeEn = sc_vld;
    assign bus.busy    = sc_vld;
endmodule

// File: tb/tb_note_plotter.sv
// Randomised bench for note_plotter: a pixel-queue reference model predicts every
// write; directed cases cover reset, extremes, drops, clear and preemption.
module tb_note_plotter;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    note_plotter_if bus();
    note_plotter dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct { int x; int y; int c; } pix_t;
    pix_t exp_q[$];
    bit   clearing = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: each accepted request expands into its full pixel list.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            exp_q.delete();
            clearing = 1'b0;
        end else begin
            bit idle, in_clr;
            idle   = (exp_q.size() == 0);
            in_clr = clearing && !idle;
            if (!idle) void'(exp_q.pop_front());
            if (bus.clear && !in_clr) begin
                exp_q.delete();
                for (int r = 0; r < 120; r++)
                    for (int c = 0; c < 160; c++) exp_q.push_back('{c, r, 0});
                clearing = 1'b1;
            end else if (idle && bus.draw && bus.note < 12) begin
                int x0, y0, col;
                x0  = bus.slot * 10;
                y0  = 112 - 2 * (bus.octave * 12 + bus.note);
                col = bus.octave + 1;
                for (int r = 0; r < 2; r++)
                    for (int c = 0; c < 8; c++) exp_q.push_back('{x0 + c, y0 + r, col});
                clearing = 1'b0;
            end
            if (exp_q.size() == 0) clearing = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            chk("busy", bus.busy, (exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                chk("wen", bus.writeEn, 1);
                chk("x", bus.x, exp_q[0].x);
                chk("y", bus.y, exp_q[0].y);
                chk("colour", bus.colour, exp_q[0].c);
                chk("xy_range", (bus.x < 160) && (bus.y < 120), 1);
            end else begin
                chk("wen", bus.writeEn, 0);
            end
        end
    end

    task automatic send(input logic d, input logic c, input logic [3:0] n,
                        input logic [1:0] o, input logic [3:0] s);
        @(negedge clk);
        bus.draw = d; bus.clear = c; bus.note = n; bus.octave = o; bus.slot = s;
        @(posedge clk);
        #1;
        bus.draw = 1'b0; bus.clear = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        int n;
        n = 0;
        @(negedge clk);
        while (bus.busy && n < max) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", bus.busy, 0);
    endtask

    initial begin
        bus.draw = 1'b0; bus.clear = 1'b0; bus.note = '0; bus.octave = '0; bus.slot = '0;
        #12;
        chk("rst_x", bus.x, 0);
        chk("rst_y", bus.y, 0);
        chk("rst_colour", bus.colour, 0);
        chk("rst_wen", bus.writeEn, 0);
        chk("rst_busy", bus.busy, 0);
        @(negedge clk);
        reset = 1'b1;

        // Single lowest block, then the highest/rightmost block.
        send(1, 0, 4'd0, 2'd0, 4'd0);
        wait_idle(40);
        send(1, 0, 4'd11, 2'd3, 4'd15);
        wait_idle(40);

        // Invalid note is ignored.
        send(1, 0, 4'd12, 2'd1, 4'd3);
        @(negedge clk);
        chk("inv_busy", bus.busy, 0);
        chk("inv_wen", bus.writeEn, 0);

        // Draw pulsed at pixel 5 of an active draw is dropped.
        send(1, 0, 4'd5, 2'd2, 4'd7);
        repeat (4) @(posedge clk);
        send(1, 0, 4'd1, 2'd0, 4'd2);
        wait_idle(40);

        // Full clear.
        send(0, 1, 4'd0, 2'd0, 4'd0);
        wait_idle(20000);

        // Clear and draw together: clear only.
        send(1, 1, 4'd3, 2'd1, 4'd4);
        wait_idle(20000);

        // Clear at pixel 9 of a draw preempts it.
        send(1, 0, 4'd7, 2'd1, 4'd9);
        repeat (8) @(posedge clk);
        send(0, 1, 4'd0, 2'd0, 4'd0);
        wait_idle(20000);

        // Reset at pixel 500 of a clear takes effect immediately.
        send(0, 1, 4'd0, 2'd0, 4'd0);
        repeat (499) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_wen", bus.writeEn, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_x", bus.x, 0);
        chk("mid_rst_y", bus.y, 0);
        chk("mid_rst_colour", bus.colour, 0);
        @(negedge clk);
        reset = 1'b1;
        send(1, 0, 4'd2, 2'd2, 4'd1);
        wait_idle(40);

        // Random draws, some invalid, some with a dropped mid-draw request.
        for (int i = 0; i < 40; i++) begin
            logic [3:0] n;
            n = 4'($urandom_range(0, 15));
            send(1, 0, n, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
            if (n < 12 && $urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 13)) @(posedge clk);
                send(1, 0, 4'($urandom_range(0, 11)), 2'($urandom_range(0, 3)),
                     4'($urandom_range(0, 15)));
            end
            wait_idle(40);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        wait_idle(40);
        chk("model_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/note_plotter.md
# note_plotter

Draws the on-screen piano-roll for the music device. Consumes note events from the datapath: 4-bit note, 2-bit octave and 4-bit sequence slot. Rasterises each event as a small coloured block and drives the pixel-write port of the 160x120 `vga_adapter` with one pixel per clock. It also performs a full-screen clear to black on request.

## Interface
Parameters:
- SCREEN_W, 160, frame width in pixels
- SCREEN_H, 120, frame height in pixels
- BLOCK_W, 8, note block width
- BLOCK_H, 2, note block height
- SLOT_PITCH, 10, horizontal spacing between slots
- Y_BASE, 112, top row of the block for pitch 0

Ports:
- clk  in  1  system clock (CLOCK_50 domain)
- reset  in  1  asynchronous, active-low reset
- draw  in  1  one-cycle request to plot a note block
- note  in  4  semitone 0..11; 12..15 invalid
- octave  in  2  octave 0..3
- slot  in  4  sequence column 0..15
- clear  in  1  one-cycle request to blank the whole frame
- x  out  8  pixel column to vga_adapter
- y  out  7  pixel row to vga_adapter
- colour  out  3  pixel colour to vga_adapter
- writeEn  out  1  plot strobe to vga_adapter
- busy  out  1  high while drawing or clearing

## Operation
- States: IDLE, DRAW, CLEAR.
- **IDLE:**
  - `clear`=1 → CLEAR.
  - Otherwise, `draw`=1 with `note`≤11 → latch inputs and go to DRAW.
  - `draw` with `note`>11 is ignored and the block stays IDLE.
- **Pitch and geometry, computed at latch:**
  - p = octave*12 + note, range 0..47, 6 bits.
  - y0 = Y_BASE − 2*p, range 18..112, 7 bits.
  - x0 = slot*SLOT_PITCH, range 0..150, 8 bits.
  - pix_colour = octave + 1, range 1..4, 3 bits. Colour 0 is reserved for clear.
- **DRAW:**
  - Emit BLOCK_W*BLOCK_H = 16 pixels in raster order, x inner: (x0..x0+7, y0), then (x0..x0+7, y0+1).
  - After the last pixel, return to IDLE.
- **CLEAR:**
  - Emit all 19200 pixels, colour 0, raster order from (0,0) to (159,119).
  - After the last pixel, return to IDLE.
- **Requests while busy:**
  - `draw` while busy is dropped. There is no queue, and the upstream issues at most one note per `busy` low window.
  - `clear` during DRAW aborts the draw. CLEAR begins at the next cycle, starting at (0,0).
  - `clear` during CLEAR is ignored.
- **Simultaneous requests:** `clear` and `draw` asserted in the same IDLE cycle: clear wins and the draw is dropped.
- **Reset values:** x=0, y=0, colour=0, writeEn=0, busy=0, state IDLE, counters 0.
- **Reset mid-operation:** reset takes effect immediately and asynchronously. Outputs go to their reset values and the partial drawing is abandoned.

## Timing
- Request sampled at cycle N.
- x, y, colour and writeEn are registered.
- The first pixel appears at cycle N+1.
- DRAW:
  - writeEn is high for cycles N+1..N+16, exactly one pixel per cycle.
  - writeEn is low at N+17.
- CLEAR: writeEn is high for cycles N+1..N+19200.
- `busy` is high in exactly the cycles writeEn is high.
- A new request is accepted in the first cycle `busy` is low. Back-to-back draws are therefore spaced by 17 cycles.
- The x counter wraps from block or frame right edge to left edge with y+1. The termination compare uses the last pixel, not overflow.
- Intermediate products must be widened:
  - slot*10 needs 8 bits.
  - 2*p needs 7 bits.
- No outputs are combinational from the inputs.

## Structure
- Package `music_pkg` holds:
  - SCREEN_W, SCREEN_H, BLOCK_W, BLOCK_H, SLOT_PITCH, Y_BASE.
  - NOTES_PER_OCTAVE=12.
  - The plotter state enum {IDLE, DRAW, CLEAR}.
  - A function for pitch→y0.
- One sub-module, `rect_scanner`, is shared by DRAW and CLEAR.
  - Inputs: origin, width and height.
  - Outputs: current x/y, valid, and a `last` flag.
  - It is loaded with a `start` pulse and advances one pixel per cycle.
- The top FSM owns request arbitration, colour selection and busy.

## Test plan
- **Reset:** assert reset mid-CLEAR at pixel 500 → writeEn, busy, x, y and colour are all 0 the same cycle. A subsequent draw works normally.
- **Single draw:** draw with note=0, octave=0, slot=0 → 16 writes, x 0..7, y 112 then 113, colour 1, busy for 16 cycles.
- **Extremes:** draw with note=11, octave=3, slot=15 → p=47, y 18..19, x 150..157, colour 4. No coordinate exceeds 159/119.
- **Invalid and busy drops:**
  - draw with note=12 → no writes, busy stays 0.
  - draw pulsed at pixel 5 of an active draw → ignored, exactly 16 writes total.
- **Clear:**
  - clear → 19200 writes, colour 0, first (0,0), last (159,119), busy drops at N+19201.
  - clear and draw asserted in the same cycle → clear only.
- **Preemption:** clear at pixel 9 of a draw → the draw stops after 9 pixels, then the full 19200-pixel clear starts from (0,0).
